// File: rtl/seq_gen_pkg.sv
// Shared types and default sizes for the serial pattern generator and its
// reference "1011" detector.
package seq_gen_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_REP_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } det_state_t;

endpackage

// File: rtl/seq1011_ref_det.sv
// Overlapping Mealy detector for "1011"; advances only on valid bits and is
// returned to S0 by clr so each job starts with a clean history.
module seq1011_ref_det
    import seq_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic x,
    input  logic x_valid,
    output logic z
);

    det_state_t state_reg;
    det_state_t state_next;

    always_comb begin
        state_next = state_reg;
        if (x_valid) begin
            case (state_reg)
                S0:      state_next = x ? S1   : S0;
                S1:      state_next = x ? S1   : S10;
                S10:     state_next = x ? S101 : S0;
                S101:    state_next = x ? S1   : S10;
                default: state_next = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S0;
        end else if (clr) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    assign z = x_valid & x & (state_reg == S101);

endmodule

// File: rtl/seq_pattern_gen.sv
// Shifts a latched pattern out MSB-first, repeated repeat_n+1 times back-to-back.
// Define SEQ_PATTERN_GEN_EXPECT_EN to build the reference "1011" detector on expect_z.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int REP_W   = DEF_REP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   repeat_n,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic               expect_z
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    gen_state_t         state_reg;
    logic [MAX_LEN-1:0] pat_reg;
    logic [IDX_W-1:0]   last_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [REP_W-1:0]   rep_reg;
    logic               x_reg;
    logic               x_valid_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [LEN_W-1:0]   len_clamped;
    logic [IDX_W-1:0]   len_last;
    logic               accept;
    logic               abort_take;

    // Only the index of the first bit is kept; the length itself is not needed afterwards.
    always_comb begin
        len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        len_last    = IDX_W'(len_clamped - LEN_W'(1));
        accept      = (state_reg == IDLE) && start && (len != '0);
        abort_take  = (state_reg == SEND) && abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pat_reg     <= '0;
            last_reg    <= '0;
            idx_reg     <= '0;
            rep_reg     <= '0;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pat_reg     <= pat;
                        last_reg    <= len_last;
                        idx_reg     <= len_last;
                        rep_reg     <= repeat_n;
                        x_reg       <= pat[len_last];
                        x_valid_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        x_reg       <= 1'b0;
                        x_valid_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end else if (idx_reg != '0) begin
                        idx_reg <= idx_reg - IDX_W'(1);
                        x_reg   <= pat_reg[idx_reg - IDX_W'(1)];
                    end else if (rep_reg != '0) begin
                        // Next pass starts on the very next cycle, no gap bit.
                        rep_reg <= rep_reg - REP_W'(1);
                        idx_reg <= last_reg;
                        x_reg   <= pat_reg[last_reg];
                    end else begin
                        state_reg   <= DONE;
                        x_reg       <= 1'b0;
                        x_valid_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign x       = x_reg;
    assign x_valid = x_valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

`ifdef SEQ_PATTERN_GEN_EXPECT_EN
    seq1011_ref_det u_ref_det (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept | abort_take),
        .x       (x_reg),
        .x_valid (x_valid_reg),
        .z       (expect_z)
    );
`else
    assign expect_z = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed cases plus random jobs
// compared against a queue-based model of the expected serial stream.
module tb_seq_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pat = '0;
    logic [4:0]  len = '0;
    logic [7:0]  repeat_n = '0;
    logic        x, x_valid, busy, done, expect_z;

    int checks = 0;
    int errors = 0;

    seq_pattern_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .pat      (pat),
        .len      (len),
        .repeat_n (repeat_n),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done),
        .expect_z (expect_z)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output frame {x, x_valid, busy, done, expect_z}.
    function automatic logic [4:0] frame();
        return {x, x_valid, busy, done, expect_z};
    endfunction

    // Reference detector output: last four bits of this job's stream are 1011.
    function automatic bit model_z(input bit q[$], input int i);
`ifdef SEQ_PATTERN_GEN_EXPECT_EN
        if (i < 3) return 1'b0;
        return q[i-3] && !q[i-2] && q[i-1] && q[i];
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [15:0] p, input int l, input int r,
                           input int restart_at, input int abort_at,
                           input int reset_at, input bit start_in_done);
        int eff;
        int n;
        bit q[$];
        eff = (l > 16) ? 16 : l;
        pat = p;
        len = l[4:0];
        repeat_n = r[7:0];
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (eff == 0) begin
            check_val("len0_reject", 32'(frame()), 32'd0);
            cyc();
            check_val("len0_idle", 32'(frame()), 32'd0);
            return;
        end
        for (int rp = 0; rp <= r; rp++)
            for (int b = eff - 1; b >= 0; b--)
                q.push_back(p[b]);
        n = q.size();
        // Inputs wander mid-job; the latched copy must be used.
        pat = 16'($urandom);
        len = 5'($urandom);
        repeat_n = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("bit%0d_of_%0d", i, n), 32'(frame()),
                      32'({q[i], 1'b1, 1'b1, 1'b0, model_z(q, i)}));
            if (i == restart_at) begin
                start = 1'b1;
                pat = ~p;
                len = 5'd8;
            end
            if (i == abort_at) begin
                abort = 1'b1;
                cyc();
                abort = 1'b0;
                start = 1'b0;
                check_val("abort_idle", 32'(frame()), 32'd0);
                cyc();
                check_val("abort_no_done", 32'(frame()), 32'd0);
                return;
            end
            if (i == reset_at) begin
                reset = 1'b0;
                #2;
                check_val("reset_async_clear", 32'(frame()), 32'd0);
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    cyc();
                    check_val("reset_stays_idle", 32'(frame()), 32'd0);
                end
                return;
            end
            cyc();
            start = 1'b0;
        end
        check_val("done_pulse", 32'(frame()), 32'b00110);
        if (start_in_done) begin
            start = 1'b1;
            len = 5'd5;
            pat = 16'hffff;
        end
        cyc();
        start = 1'b0;
        check_val("idle_after_done", 32'(frame()), 32'd0);
        if (start_in_done) begin
            cyc();
            check_val("done_start_ignored", 32'(frame()), 32'd0);
        end
    endtask

    initial begin
        #2;
        check_val("reset_state", 32'(frame()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        check_val("idle_after_release", 32'(frame()), 32'd0);

        run_job(16'b1011011, 7, 0, -1, -1, -1, 1'b0);
        run_job(16'b101, 3, 2, -1, -1, -1, 1'b0);
        run_job(16'hABCD, 0, 1, -1, -1, -1, 1'b0);
        run_job(16'h00B2, 8, 0, 2, -1, -1, 1'b0);
        run_job(16'hC3A5, 20, 0, -1, -1, -1, 1'b0);
        run_job(16'h00B0, 8, 0, -1, 2, -1, 1'b0);
        run_job(16'h000B, 4, 0, -1, -1, -1, 1'b0);
        run_job(16'h0005, 3, 3, -1, -1, 4, 1'b0);
        run_job(16'h000F, 4, 1, -1, -1, -1, 1'b1);

        for (int j = 0; j < 25; j++) begin
            logic [15:0] rp;
            int rl, rr, ra, rs;
            rp = 16'($urandom);
            rl = $urandom_range(0, 20);
            rr = $urandom_range(0, 3);
            ra = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
            rs = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
            run_job(rp, rl, rr, rs, ra, -1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial stimulus transmitter for the serial-bit sequence detectors. It loads a parallel bit pattern and shifts it out MSB-first, one bit per clock, on the detector's `x` input. The pattern can be repeated back-to-back, with a start/busy/done handshake. It is the driving end of the detector's `x` interface. It replaces hand-written `#10 x=...` stimulus and lets long or overlapping streams, such as 1011011, be scripted from a single start.

Parameters:
- MAX_LEN, 16, widest pattern in bits; `pat` width.
- LEN_W, $clog2(MAX_LEN+1), width of `len`.
- REP_W, 8, width of `repeat_n`.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  in  1  request, sampled in IDLE only.
- abort  in  1  terminate the job in progress.
- pat  in  MAX_LEN  pattern; bit [len-1] is sent first, bit [0] last.
- len  in  LEN_W  pattern length in bits.
- repeat_n  in  REP_W  extra passes; total passes = repeat_n+1.
- x  out  1  serial bit, drives the detector's `x`.
- x_valid  out  1  x carries a pattern bit this cycle.
- busy  out  1  job accepted and not finished.
- done  out  1  one-cycle pulse after the final bit.
- expect_z  out  1  reference detector output; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - x=0, x_valid=0, busy=0, done=0, expect_z=0.
  - Internal counters cleared.
- FSM states: IDLE, SEND, DONE. All outputs except expect_z are registered.
- IDLE:
  - start=1 with len!=0 at edge k: latch pat, len and repeat_n; go to SEND.
  - From edge k the following hold: busy=1, x_valid=1, x=pat[len-1], bit index=len-1, rep_cnt=repeat_n.
  - start=1 with len=0: ignored; stay in IDLE, no busy, no done.
  - len>MAX_LEN: clamped to MAX_LEN.
- SEND, each edge:
  - If index>0: index decrements; x takes the next lower bit.
  - If index=0 and rep_cnt>0: rep_cnt decrements; index reloads to len-1; x=pat[len-1]. There is no gap cycle between passes.
  - If index=0 and rep_cnt=0: go to DONE; x=0, x_valid=0, done=1.
  - Net effect: x_valid is high for exactly len*(repeat_n+1) consecutive cycles.
- DONE: lasts one cycle. Next edge goes to IDLE; done=0, busy=0.
  - A start that is high during DONE is not accepted; it must be held or re-asserted in IDLE.
- start while busy: ignored. Latched pat, len and repeat_n are unaffected by input changes mid-job.
- abort=1 in SEND:
  - Next edge: IDLE; x=0, x_valid=0, busy=0.
  - done is not pulsed.
  - abort has priority over the bit advance.
  - abort in IDLE or DONE: no effect.
- Simultaneous start and abort in IDLE: start wins; abort is only examined in SEND.
- Reset mid-job: outputs drop asynchronously; after release the block is in IDLE and needs a fresh start.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_EXPECT_EN.
- With the macro defined: an internal overlapping Mealy detector for "1011" observes (x, x_valid).
  - Detector states: S0, S1, S10, S101.
  - The detector advances only when x_valid=1.
  - It is forced to S0 on job accept and on abort.
  - expect_z = x_valid & x & (det_state==S101), combinational and cycle-aligned with x. It matches the detector's z for the same stream.
- Without the macro: no detector logic is built; expect_z is tied to 0.

Decomposition:
- Shared package seq_gen_pkg holds:
  - the FSM state enum (IDLE, SEND, DONE);
  - the detector state enum (S0, S1, S10, S101);
  - the default MAX_LEN and REP_W constants.
- One sub-module, seq1011_ref_det, holds the reference detector. It has ports clk, reset, clr, x, x_valid and z, and is instantiated only under the macro.

Test Plan:
- Basic stream: pat=7'b1011011, len=7, repeat_n=0, one-cycle start.
  - x over 7 cycles is 1,0,1,1,0,1,1, with x_valid high throughout.
  - done pulses on the 8th cycle; busy falls the cycle after.
  - With the macro, expect_z=1 on the 4th and 7th bits.
- Repeat: pat=3'b101, len=3, repeat_n=2.
  - x is 101101101 with 9 contiguous valid cycles and no gap.
  - Exactly one done pulse.
  - With the macro, expect_z=1 on bits 4 and 7.
- Rejected starts:
  - start with len=0: busy, x_valid and done stay 0.
  - start re-asserted at cycle 3 of a len=8 job, with different pat: stream is unchanged; still 8 bits.
- Clamp: len=20 with MAX_LEN=16: exactly 16 bits sent, starting from pat[15].
- Abort: abort during bit 3 of a len=8 job.
  - Next cycle: x_valid=0, busy=0; done is never pulsed.
  - A following start runs a full job, with expect_z history cleared.
- Reset mid-job: pull reset low during the second pass of a repeat_n=3 job.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release: IDLE, and no bits are emitted until a new start.
